// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control unit: state register, IR opcode/funct latch,
// Moore-style datapath strobes, memory-ready watchdog and retire counter.
// Build option: define ILLEGAL_TRAP_EN to send unsupported instructions to
// a sticky TRAP state; otherwise they retire nothing and fall back to IF.
//
// state | meaning
// ID    | decode, latch A/B, precompute branch target; J/JR finish here
// IF    | fetch, wait for mem_ready, latch opcode/funct
// EXEC  | ALU operation; branches resolve here
// MEM   | data access, wait for mem_ready
// WB    | register write-back (and JAL jump)
// TRAP  | illegal instruction, held until reset (ILLEGAL_TRAP_EN only)
module multicycle_ctrl_fsm #(
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               mem_ready,
    input  logic               zero,
    output logic [2:0]         state,
    output logic               pc_we,
    output logic               ir_we,
    output logic               mem_we,
    output logic               a_we,
    output logic               b_we,
    output logic               reg_we,
    output logic               mem_in,
    output logic [1:0]         dst,
    output logic [1:0]         reg_in,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               mem_timeout,
    output logic               trap,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_ID   = 3'd0,
        S_IF   = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP = 3'd5
`endif
    } state_t;

    typedef struct packed {
        logic               pc_we;
        logic               ir_we;
        logic               mem_we;
        logic               a_we;
        logic               b_we;
        logic               reg_we;
        logic               mem_in;
        logic               trap;
        logic [1:0]         dst;
        logic [1:0]         reg_in;
        logic [1:0]         alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_src;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3);
    localparam logic [7:0]         WAIT_LIM = 8'(WAIT_MAX);

    state_t           state_q, state_next;
    logic [5:0]       op_q, fn_q;
    logic [7:0]       wait_cnt;
    logic             timeout_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire_inc;
    logic             stalled;
    ctrl_t            ctrl, ctrl_g;
    logic             is_jr, is_r_alu, is_supported;
    logic             unused_instr;

    assign unused_instr = ^instr[25:6];

    assign is_jr        = (op_q == OP_RTYPE) && (fn_q == FN_JR);
    assign is_r_alu     = (op_q == OP_RTYPE) &&
                          ((fn_q == FN_ADD) || (fn_q == FN_SUB) || (fn_q == FN_SLT));
    assign is_supported = is_r_alu || (op_q == OP_LW) || (op_q == OP_SW) ||
                          (op_q == OP_ADDI) || (op_q == OP_XORI) ||
                          (op_q == OP_BEQ) || (op_q == OP_BNE);
    assign stalled      = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;

    // State register, IR field latch and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            op_q      <= 6'd0;
            fn_q      <= 6'd0;
            retired_q <= '0;
        end else begin
            state_q <= state_next;
            if ((state_q == S_IF) && mem_ready) begin
                op_q <= instr[31:26];
                fn_q <= instr[5:0];
            end
            if (retire_inc)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Watchdog: count consecutive stalled cycles, sticky flag at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else if (stalled) begin
            if (wait_cnt != WAIT_LIM)
                wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == WAIT_LIM)
                timeout_q <= 1'b1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Next-state and strobe decode from (state, latched opcode, latched funct)
    always_comb begin
        ctrl       = '0;
        state_next = state_q;
        retire_inc = 1'b0;
        unique case (state_q)
            S_IF: begin
                ctrl.alu_src_b = 2'd1;
                ctrl.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctrl.ir_we = 1'b1;
                    ctrl.pc_we = 1'b1;
                    state_next = S_ID;
                end
            end
            S_ID: begin
                ctrl.a_we      = 1'b1;
                ctrl.b_we      = 1'b1;
                ctrl.alu_src_b = 2'd3;
                ctrl.alu_op    = ALU_ADD;
                if (op_q == OP_J) begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_src = 2'd2;
                    retire_inc  = 1'b1;
                    state_next  = S_IF;
                end else if (op_q == OP_JAL) begin
                    state_next = S_WB;
                end else if (is_jr) begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_src = 2'd3;
                    retire_inc  = 1'b1;
                    state_next  = S_IF;
                end else if (is_supported) begin
                    state_next = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
`else
                    state_next = S_IF;
`endif
                end
            end
            S_EXEC: begin
                ctrl.alu_src_a = 2'd1;
                state_next     = S_IF;
                if (is_r_alu) begin
                    ctrl.alu_op = (fn_q == FN_SUB) ? ALU_SUB :
                                  (fn_q == FN_SLT) ? ALU_SLT : ALU_ADD;
                    state_next  = S_WB;
                end else if ((op_q == OP_ADDI) || (op_q == OP_XORI)) begin
                    ctrl.alu_src_b = 2'd2;
                    ctrl.alu_op    = (op_q == OP_XORI) ? ALU_XOR : ALU_ADD;
                    state_next     = S_WB;
                end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    ctrl.alu_src_b = 2'd2;
                    state_next     = S_MEM;
                end else if ((op_q == OP_BEQ) || (op_q == OP_BNE)) begin
                    ctrl.alu_op = ALU_SUB;
                    ctrl.pc_src = 2'd1;
                    ctrl.pc_we  = (op_q == OP_BEQ) ? zero : !zero;
                    retire_inc  = 1'b1;
                end
            end
            S_MEM: begin
                ctrl.mem_in = 1'b1;
                ctrl.mem_we = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_next = S_WB;
                    end else begin
                        retire_inc = (op_q == OP_SW);
                        state_next = S_IF;
                    end
                end
            end
            S_WB: begin
                ctrl.reg_we = 1'b1;
                retire_inc  = 1'b1;
                state_next  = S_IF;
                if (op_q == OP_LW) begin
                    ctrl.reg_in = 2'd1;
                end else if (op_q == OP_JAL) begin
                    ctrl.dst    = 2'd2;
                    ctrl.reg_in = 2'd2;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_src = 2'd2;
                end else if (op_q == OP_RTYPE) begin
                    ctrl.dst = 2'd1;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl.trap = 1'b1;
            end
`endif
            default: begin
                state_next = S_IF;
            end
        endcase
    end

    // Reset forces every strobe low immediately, independent of the clock
    assign ctrl_g = rst_n ? ctrl : '0;

    assign state       = state_q;
    assign pc_we       = ctrl_g.pc_we;
    assign ir_we       = ctrl_g.ir_we;
    assign mem_we      = ctrl_g.mem_we;
    assign a_we        = ctrl_g.a_we;
    assign b_we        = ctrl_g.b_we;
    assign reg_we      = ctrl_g.reg_we;
    assign mem_in      = ctrl_g.mem_in;
    assign trap        = ctrl_g.trap;
    assign dst         = ctrl_g.dst;
    assign reg_in      = ctrl_g.reg_in;
    assign alu_src_a   = ctrl_g.alu_src_a;
    assign alu_src_b   = ctrl_g.alu_src_b;
    assign alu_op      = ctrl_g.alu_op;
    assign pc_src      = ctrl_g.pc_src;
    assign mem_timeout = timeout_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: a vector table walking one
// instruction of each class, then reset-abort and watchdog sequences.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_ctrl_fsm;

    localparam int ALUOP_W  = 3;
    localparam int CNT_W    = 16;
    localparam int WAIT_MAX = 15;

    localparam logic [31:0] ADD_I  = 32'h0022_1820;
    localparam logic [31:0] SUB_I  = 32'h0022_1822;
    localparam logic [31:0] SLT_I  = 32'h0022_182A;
    localparam logic [31:0] LW_I   = 32'h8C22_0004;
    localparam logic [31:0] SW_I   = 32'hAC22_0004;
    localparam logic [31:0] BEQ_I  = 32'h1022_0002;
    localparam logic [31:0] BNE_I  = 32'h1422_0002;
    localparam logic [31:0] JAL_I  = 32'h0C00_0100;
    localparam logic [31:0] J_I    = 32'h0800_0100;
    localparam logic [31:0] JR_I   = 32'h03E0_0008;
    localparam logic [31:0] XORI_I = 32'h3822_0005;
    localparam logic [31:0] ILL_I  = 32'hFC00_0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [31:0]        instr;
    logic               mem_ready;
    logic               zero;
    logic [2:0]         state;
    logic               pc_we, ir_we, mem_we, a_we, b_we, reg_we, mem_in;
    logic [1:0]         dst, reg_in, alu_src_a, alu_src_b, pc_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_timeout, trap;
    logic [CNT_W-1:0]   retired;

    typedef struct packed {
        logic [2:0]         state;
        logic               pc_we;
        logic               ir_we;
        logic               mem_we;
        logic               a_we;
        logic               b_we;
        logic               reg_we;
        logic               mem_in;
        logic [1:0]         dst;
        logic [1:0]         reg_in;
        logic [1:0]         alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_src;
        logic               mem_timeout;
        logic               trap;
        logic [CNT_W-1:0]   retired;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        mr;
        logic        zero;
        out_t        exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    out_t act;

    assign act = {state, pc_we, ir_we, mem_we, a_we, b_we, reg_we, mem_in,
                  dst, reg_in, alu_src_a, alu_src_b, alu_op, pc_src,
                  mem_timeout, trap, retired};

    multicycle_ctrl_fsm #(
        .ALUOP_W (ALUOP_W),
        .CNT_W   (CNT_W),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .state      (state),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .mem_we     (mem_we),
        .a_we       (a_we),
        .b_we       (b_we),
        .reg_we     (reg_we),
        .mem_in     (mem_in),
        .dst        (dst),
        .reg_in     (reg_in),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .mem_timeout(mem_timeout),
        .trap       (trap),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic out_t f_st(logic [2:0] st, int ret);
        out_t o;
        o         = '0;
        o.state   = st;
        o.retired = CNT_W'(ret);
        return o;
    endfunction

    function automatic out_t f_if(logic rdy, int ret);
        out_t o;
        o           = f_st(3'd1, ret);
        o.alu_src_b = 2'd1;
        o.pc_we     = rdy;
        o.ir_we     = rdy;
        return o;
    endfunction

    function automatic out_t f_id(int ret);
        out_t o;
        o           = f_st(3'd0, ret);
        o.a_we      = 1'b1;
        o.b_we      = 1'b1;
        o.alu_src_b = 2'd3;
        return o;
    endfunction

    task automatic add(logic [31:0] i, logic mr, logic z, out_t e);
        vec_t v;
        v.instr = i;
        v.mr    = mr;
        v.zero  = z;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    // Entered at a negedge: drive, let outputs settle, compare, wait next negedge
    task automatic step(string name, logic [31:0] i, logic mr, logic z, out_t e);
        instr     = i;
        mem_ready = mr;
        zero      = z;
        #1;
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (state got %0d want %0d)",
                     name, act, e, act.state, e.state);
        end
        @(negedge clk);
    endtask

    initial begin
        out_t e;

        // ADD r3,r1,r2
        add(ADD_I, 1'b1, 1'b0, f_if(1'b1, 0));
        add(32'd0, 1'b0, 1'b0, f_id(0));
        e = f_st(3'd2, 0); e.alu_src_a = 2'd1;                           add(32'd0, 1'b0, 1'b0, e);
        e = f_st(3'd4, 0); e.reg_we = 1'b1; e.dst = 2'd1;                add(32'd0, 1'b0, 1'b0, e);
        // LW with three stalled MEM cycles
        add(LW_I, 1'b1, 1'b0, f_if(1'b1, 1));
        add(32'd0, 1'b0, 1'b0, f_id(1));
        e = f_st(3'd2, 1); e.alu_src_a = 2'd1; e.alu_src_b = 2'd2;       add(32'd0, 1'b0, 1'b0, e);
        e = f_st(3'd3, 1); e.mem_in = 1'b1;
        add(32'd0, 1'b0, 1'b0, e); add(32'd0, 1'b0, 1'b0, e); add(32'd0, 1'b0, 1'b0, e);
        add(32'd0, 1'b1, 1'b0, e);
        e = f_st(3'd4, 1); e.reg_we = 1'b1; e.reg_in = 2'd1;             add(32'd0, 1'b0, 1'b0, e);
        // BEQ taken (zero=1)
        add(BEQ_I, 1'b1, 1'b0, f_if(1'b1, 2));
        add(32'd0, 1'b0, 1'b1, f_id(2));
        e = f_st(3'd2, 2); e.alu_src_a = 2'd1; e.alu_op = 3'd1; e.pc_src = 2'd1; e.pc_we = 1'b1;
        add(32'd0, 1'b0, 1'b1, e);
        // BNE not taken (zero=1)
        add(BNE_I, 1'b1, 1'b1, f_if(1'b1, 3));
        add(32'd0, 1'b0, 1'b1, f_id(3));
        e = f_st(3'd2, 3); e.alu_src_a = 2'd1; e.alu_op = 3'd1; e.pc_src = 2'd1;
        add(32'd0, 1'b0, 1'b1, e);
        // JAL
        add(JAL_I, 1'b1, 1'b0, f_if(1'b1, 4));
        add(32'd0, 1'b0, 1'b0, f_id(4));
        e = f_st(3'd4, 4); e.reg_we = 1'b1; e.dst = 2'd2; e.reg_in = 2'd2; e.pc_we = 1'b1; e.pc_src = 2'd2;
        add(32'd0, 1'b0, 1'b0, e);
        // SW with one stalled MEM cycle
        add(SW_I, 1'b1, 1'b0, f_if(1'b1, 5));
        add(32'd0, 1'b0, 1'b0, f_id(5));
        e = f_st(3'd2, 5); e.alu_src_a = 2'd1; e.alu_src_b = 2'd2;       add(32'd0, 1'b0, 1'b0, e);
        e = f_st(3'd3, 5); e.mem_in = 1'b1; e.mem_we = 1'b1;
        add(32'd0, 1'b0, 1'b0, e); add(32'd0, 1'b1, 1'b0, e);
        // XORI
        add(XORI_I, 1'b1, 1'b0, f_if(1'b1, 6));
        add(32'd0, 1'b0, 1'b0, f_id(6));
        e = f_st(3'd2, 6); e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.alu_op = 3'd2;
        add(32'd0, 1'b0, 1'b0, e);
        e = f_st(3'd4, 6); e.reg_we = 1'b1;                              add(32'd0, 1'b0, 1'b0, e);
        // SUB
        add(SUB_I, 1'b1, 1'b0, f_if(1'b1, 7));
        add(32'd0, 1'b0, 1'b0, f_id(7));
        e = f_st(3'd2, 7); e.alu_src_a = 2'd1; e.alu_op = 3'd1;          add(32'd0, 1'b0, 1'b0, e);
        e = f_st(3'd4, 7); e.reg_we = 1'b1; e.dst = 2'd1;                add(32'd0, 1'b0, 1'b0, e);
        // JR finishes in ID
        add(JR_I, 1'b1, 1'b0, f_if(1'b1, 8));
        e = f_id(8); e.pc_we = 1'b1; e.pc_src = 2'd3;                    add(32'd0, 1'b0, 1'b0, e);
        // SLT
        add(SLT_I, 1'b1, 1'b0, f_if(1'b1, 9));
        add(32'd0, 1'b0, 1'b0, f_id(9));
        e = f_st(3'd2, 9); e.alu_src_a = 2'd1; e.alu_op = 3'd3;          add(32'd0, 1'b0, 1'b0, e);
        e = f_st(3'd4, 9); e.reg_we = 1'b1; e.dst = 2'd1;                add(32'd0, 1'b0, 1'b0, e);
        // J finishes in ID
        add(J_I, 1'b1, 1'b0, f_if(1'b1, 10));
        e = f_id(10); e.pc_we = 1'b1; e.pc_src = 2'd2;                   add(32'd0, 1'b0, 1'b0, e);
        // Illegal opcode 111111
        add(ILL_I, 1'b1, 1'b0, f_if(1'b1, 11));
        add(32'd0, 1'b0, 1'b0, f_id(11));
`ifdef ILLEGAL_TRAP_EN
        e = f_st(3'd5, 11); e.trap = 1'b1;
        add(ADD_I, 1'b1, 1'b0, e); add(ADD_I, 1'b1, 1'b0, e); add(32'd0, 1'b0, 1'b0, e);
`else
        add(32'd0, 1'b0, 1'b0, f_if(1'b0, 11));
        add(ADD_I, 1'b1, 1'b0, f_if(1'b1, 11));
        add(32'd0, 1'b0, 1'b0, f_id(11));
`endif

        rst_n     = 1'b0;
        instr     = 32'd0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        @(negedge clk);
        step("reset", 32'd0, 1'b0, 1'b0, f_st(3'd1, 0));
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++)
            step($sformatf("vec%0d", k), vecs[k].instr, vecs[k].mr, vecs[k].zero, vecs[k].exp);

        // Reset from wherever the table left off clears retired and strobes
        rst_n = 1'b0;
        step("rst_after_table", 32'd0, 1'b1, 1'b0, f_st(3'd1, 0));
        rst_n = 1'b1;

        // Reset in the middle of an instruction aborts straight to IF
        step("abort_if", ADD_I, 1'b1, 1'b0, f_if(1'b1, 0));
        step("abort_id", 32'd0, 1'b0, 1'b0, f_id(0));
        e = f_st(3'd2, 0); e.alu_src_a = 2'd1;
        step("abort_exec", 32'd0, 1'b0, 1'b0, e);
        rst_n = 1'b0;
        step("abort_rst", 32'd0, 1'b1, 1'b0, f_st(3'd1, 0));
        rst_n = 1'b1;

        // Watchdog: flag rises after the 15th stalled IF cycle and sticks
        for (int i = 0; i < 20; i++) begin
            e = f_if(1'b0, 0);
            e.mem_timeout = (i >= WAIT_MAX);
            step($sformatf("wdog%0d", i), 32'd0, 1'b0, 1'b0, e);
        end
        e = f_if(1'b1, 0); e.mem_timeout = 1'b1;
        step("wdog_ready", ADD_I, 1'b1, 1'b0, e);
        e = f_id(0); e.mem_timeout = 1'b1;
        step("wdog_sticky", 32'd0, 1'b0, 1'b0, e);
        rst_n = 1'b0;
        step("wdog_rst", 32'd0, 1'b0, 1'b0, f_st(3'd1, 0));
        rst_n = 1'b1;
        step("wdog_clear", 32'd0, 1'b0, 1'b0, f_if(1'b0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
